// File: rtl/multi_timer_control.sv
// N-channel timer core: counters, compare-match clearing, pairwise cascade,
// sticky event flags with interrupt gating, output-pin actions and ADC start.
module multi_timer_control #(
  parameter int BIT_WIDTH = 8,
  parameter int N_CH      = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CH-1:0]           tick,
  input  logic [N_CH-1:0]           tmri,
  input  logic [N_CH*BIT_WIDTH-1:0] tcora,
  input  logic [N_CH*BIT_WIDTH-1:0] tcorb,
  input  logic [2*N_CH-1:0]         cclr,
  input  logic [4*N_CH-1:0]         os,
  input  logic [3*N_CH-1:0]         ie,
  input  logic [3*N_CH-1:0]         flag_clr,
  input  logic [N_CH/2-1:0]         cascade,
  input  logic                      adte,
  output logic [N_CH*BIT_WIDTH-1:0] tcnt,
  output logic [3*N_CH-1:0]         flags,
  output logic [N_CH-1:0]           cmia,
  output logic [N_CH-1:0]           cmib,
  output logic [N_CH-1:0]           ovi,
  output logic [N_CH-1:0]           tmo,
  output logic                      adc_request
);

  localparam int W  = BIT_WIDTH;
  localparam int NP = N_CH / 2;

  logic [N_CH-1:0] tmri_s1, tmri_s2, tmri_d, tmri_rise;
  logic [N_CH-1:0] eff_tick, match_a;
  logic [NP-1:0]   odd_ovf;

  function automatic logic cmp_clear(input logic t, input logic [W-1:0] cnt,
                                     input logic [W-1:0] cora, input logic [W-1:0] corb,
                                     input logic [1:0] sel);
    return t & (((sel == 2'b01) & (cnt == cora)) | ((sel == 2'b10) & (cnt == corb)));
  endfunction

  function automatic logic pin_action(input logic [1:0] act, input logic cur);
    case (act)
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      2'b11:   return ~cur;
      default: return cur;
    endcase
  endfunction

  // tmri is asynchronous: two-flop synchroniser, then a third flop for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmri_s1 <= '0;
      tmri_s2 <= '0;
      tmri_d  <= '0;
    end else begin
      tmri_s1 <= tmri;
      tmri_s2 <= tmri_s1;
      tmri_d  <= tmri_s2;
    end
  end

  assign tmri_rise = tmri_s2 & ~tmri_d;

  // Odd-channel overflow is derived from raw inputs so the even channel's
  // cascaded tick has no combinational path back through its own logic.
  for (genvar k = 0; k < NP; k++) begin : g_pair
    localparam int O = 2 * k + 1;
    logic          o_tclr;
    assign o_tclr     = (cclr[2*O +: 2] == 2'b11) & tmri_rise[O];
    assign odd_ovf[k] = tick[O] & (&tcnt[O*W +: W]) & ~o_tclr
                      & ~cmp_clear(tick[O], tcnt[O*W +: W], tcora[O*W +: W],
                                   tcorb[O*W +: W], cclr[2*O +: 2]);
    assign eff_tick[O]   = tick[O];
    assign eff_tick[2*k] = cascade[k] ? odd_ovf[k] : tick[2*k];
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [W-1:0] cnt_q, cora, corb;
    logic [1:0]   sel, act_a, act_b;
    logic [2:0]   flg_q, flg_set;
    logic         tmo_q, mat_a, mat_b, tclr, cclr_hit, ovf_evt;

    assign cora     = tcora[i*W +: W];
    assign corb     = tcorb[i*W +: W];
    assign sel      = cclr[2*i +: 2];
    assign act_a    = os[4*i +: 2];
    assign act_b    = os[4*i+2 +: 2];
    assign mat_a    = eff_tick[i] & (cnt_q == cora);
    assign mat_b    = eff_tick[i] & (cnt_q == corb);
    assign tclr     = (sel == 2'b11) & tmri_rise[i];
    assign cclr_hit = cmp_clear(eff_tick[i], cnt_q, cora, corb, sel);
    assign ovf_evt  = eff_tick[i] & (&cnt_q) & ~cclr_hit & ~tclr;
    assign flg_set  = {ovf_evt, mat_b, mat_a};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        flg_q <= '0;
        tmo_q <= 1'b0;
      end else begin
        if (tclr || cclr_hit) cnt_q <= '0;
        else if (eff_tick[i]) cnt_q <= cnt_q + 1'b1;
        // a set in the same cycle as a clear pulse must survive
        flg_q <= flg_set | (flg_q & ~flag_clr[3*i +: 3]);
        if (mat_a && (act_a != 2'b00)) tmo_q <= pin_action(act_a, tmo_q);
        else if (mat_b)                tmo_q <= pin_action(act_b, tmo_q);
      end
    end

    assign tcnt[i*W +: W]   = cnt_q;
    assign flags[3*i +: 3]  = flg_q;
    assign cmia[i]          = flg_q[0] & ie[3*i];
    assign cmib[i]          = flg_q[1] & ie[3*i+1];
    assign ovi[i]           = flg_q[2] & ie[3*i+2];
    assign tmo[i]           = tmo_q;
    assign match_a[i]       = mat_a;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) adc_request <= 1'b0;
    else        adc_request <= adte & match_a[0];
  end

endmodule

// File: tb/tb_multi_timer_control.sv
// Directed bench for multi_timer_control (BIT_WIDTH=8, N_CH=2).
module tb_multi_timer_control;
  localparam int W = 8;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   tick, tmri;
  logic [N*W-1:0] tcora, tcorb;
  logic [2*N-1:0] cclr;
  logic [4*N-1:0] os;
  logic [3*N-1:0] ie, flag_clr;
  logic [N/2-1:0] cascade;
  logic           adte;
  logic [N*W-1:0] tcnt;
  logic [3*N-1:0] flags;
  logic [N-1:0]   cmia, cmib, ovi, tmo;
  logic           adc_request;

  int checks = 0;
  int passes = 0;

  multi_timer_control #(.BIT_WIDTH(W), .N_CH(N)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .tmri(tmri), .tcora(tcora), .tcorb(tcorb),
    .cclr(cclr), .os(os), .ie(ie), .flag_clr(flag_clr), .cascade(cascade), .adte(adte),
    .tcnt(tcnt), .flags(flags), .cmia(cmia), .cmib(cmib), .ovi(ovi), .tmo(tmo),
    .adc_request(adc_request)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    tick = '0; tmri = '0; tcora = '0; tcorb = '0; cclr = '0; os = '0;
    ie = '0; flag_clr = '0; cascade = '0; adte = 1'b0;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    clear_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #3;
    checks++; if (tcnt !== '0) $display("FAIL reset_tcnt: got %h want 0000", tcnt); else passes++;
    checks++; if (flags !== '0) $display("FAIL reset_flags: got %b want 000000", flags); else passes++;
    checks++; if (tmo !== '0 || adc_request !== 1'b0) $display("FAIL reset_out: tmo=%b adc=%b want 0", tmo, adc_request); else passes++;
    checks++; if ({cmia, cmib, ovi} !== '0) $display("FAIL reset_irq: got %b want 0", {cmia, cmib, ovi}); else passes++;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_match_a();
    logic [7:0] exp_cnt;
    logic       exp_tmo;
    do_reset();
    cclr[1:0] = 2'b01; tcora[7:0] = 8'h05; os[3:0] = 4'b0011; ie[0] = 1'b1; tick[0] = 1'b1;
    exp_cnt = 8'h00; exp_tmo = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      step();
      if (exp_cnt == 8'h05) begin exp_cnt = 8'h00; exp_tmo = ~exp_tmo; end
      else exp_cnt = exp_cnt + 8'h01;
      checks++; if (tcnt[7:0] !== exp_cnt || tmo[0] !== exp_tmo)
        $display("FAIL match_a_seq[%0d]: tcnt0=%h tmo0=%b want %h %b", j, tcnt[7:0], tmo[0], exp_cnt, exp_tmo);
      else passes++;
      if (j == 5) begin
        checks++; if (flags[0] !== 1'b0 || cmia[0] !== 1'b0) $display("FAIL cmfa_early: cmfa=%b cmia=%b want 0", flags[0], cmia[0]); else passes++;
      end
      if (j == 6) begin
        checks++; if (flags[0] !== 1'b1 || cmia[0] !== 1'b1) $display("FAIL cmfa_set: cmfa=%b cmia=%b want 1", flags[0], cmia[0]); else passes++;
      end
    end
    tick[0] = 1'b0; flag_clr[0] = 1'b1;
    step();
    flag_clr[0] = 1'b0;
    checks++; if (flags[0] !== 1'b0 || cmia[0] !== 1'b0) $display("FAIL cmfa_clear: cmfa=%b cmia=%b want 0", flags[0], cmia[0]); else passes++;
    checks++; if (tcnt[15:8] !== 8'h00) $display("FAIL ch1_idle: got %h want 00", tcnt[15:8]); else passes++;
  endtask

  task automatic test_overflow();
    do_reset();
    ie[5] = 1'b1; tick[1] = 1'b1;
    repeat (255) step();
    checks++; if (tcnt[15:8] !== 8'hFF || flags[5] !== 1'b0) $display("FAIL ovf_pre: tcnt1=%h ovf=%b want ff 0", tcnt[15:8], flags[5]); else passes++;
    step();
    checks++; if (tcnt[15:8] !== 8'h00 || flags[5] !== 1'b1 || ovi[1] !== 1'b1)
      $display("FAIL ovf_wrap: tcnt1=%h ovf=%b ovi=%b want 00 1 1", tcnt[15:8], flags[5], ovi[1]);
    else passes++;
    flag_clr[5] = 1'b1;
    step();
    flag_clr[5] = 1'b0;
    checks++; if (tcnt[15:8] !== 8'h01 || flags[5] !== 1'b0) $display("FAIL ovf_clear: tcnt1=%h ovf=%b want 01 0", tcnt[15:8], flags[5]); else passes++;
    repeat (254) step();
    checks++; if (tcnt[15:8] !== 8'hFF) $display("FAIL ovf_pre2: tcnt1=%h want ff", tcnt[15:8]); else passes++;
    flag_clr[5] = 1'b1;
    step();
    flag_clr[5] = 1'b0;
    checks++; if (tcnt[15:8] !== 8'h00 || flags[5] !== 1'b1) $display("FAIL ovf_set_wins: tcnt1=%h ovf=%b want 00 1", tcnt[15:8], flags[5]); else passes++;
  endtask

  task automatic test_cascade();
    do_reset();
    cascade[0] = 1'b1; tick[1] = 1'b1;
    repeat (255) step();
    checks++; if (tcnt !== 16'hFF00) $display("FAIL casc_255: tcnt=%h want ff00", tcnt); else passes++;
    step();
    checks++; if (tcnt !== 16'h0001) $display("FAIL casc_256: tcnt=%h want 0001", tcnt); else passes++;
    repeat (256) step();
    checks++; if ({tcnt[7:0], tcnt[15:8]} !== 16'h0200) $display("FAIL casc_512: {tcnt0,tcnt1}=%h want 0200", {tcnt[7:0], tcnt[15:8]}); else passes++;
    checks++; if (flags[5] !== 1'b1 || flags[2] !== 1'b0) $display("FAIL casc_ovf: ovf1=%b ovf0=%b want 1 0", flags[5], flags[2]); else passes++;
  endtask

  task automatic test_tmri();
    do_reset();
    tick[0] = 1'b1;
    repeat (64) step();
    tick[0] = 1'b0;
    checks++; if (tcnt[7:0] !== 8'h40) $display("FAIL tmri_setup: tcnt0=%h want 40", tcnt[7:0]); else passes++;
    cclr[1:0] = 2'b11; tmri[0] = 1'b1;
    step();
    step();
    checks++; if (tcnt[7:0] !== 8'h40) $display("FAIL tmri_latency: tcnt0=%h want 40", tcnt[7:0]); else passes++;
    step();
    checks++; if (tcnt[7:0] !== 8'h00) $display("FAIL tmri_clear: tcnt0=%h want 00", tcnt[7:0]); else passes++;
    tmri[0] = 1'b0; tick[0] = 1'b1;
    repeat (3) step();
    checks++; if (tcnt[7:0] !== 8'h03) $display("FAIL tmri_once: tcnt0=%h want 03", tcnt[7:0]); else passes++;
    tmri[0] = 1'b1;
    repeat (3) step();
    checks++; if (tcnt[7:0] !== 8'h00) $display("FAIL tmri_held_clear: tcnt0=%h want 00", tcnt[7:0]); else passes++;
    repeat (7) step();
    checks++; if (tcnt[7:0] !== 8'h07) $display("FAIL tmri_held_once: tcnt0=%h want 07", tcnt[7:0]); else passes++;
  endtask

  task automatic test_simul_match();
    do_reset();
    cclr[1:0] = 2'b01; tcora[7:0] = 8'h03; tcorb[7:0] = 8'h03; os[3:0] = 4'b1000; tick[0] = 1'b1;
    repeat (3) step();
    checks++; if (tmo[0] !== 1'b0 || flags[1:0] !== 2'b00) $display("FAIL sim_pre: tmo0=%b cmf=%b want 0 00", tmo[0], flags[1:0]); else passes++;
    step();
    checks++; if (tmo[0] !== 1'b1 || flags[1:0] !== 2'b11 || tcnt[7:0] !== 8'h00)
      $display("FAIL sim_b_only: tmo0=%b cmf=%b tcnt0=%h want 1 11 00", tmo[0], flags[1:0], tcnt[7:0]);
    else passes++;
    os[3:0] = 4'b1001;
    repeat (4) step();
    checks++; if (tmo[0] !== 1'b0 || flags[1:0] !== 2'b11) $display("FAIL sim_a_wins: tmo0=%b cmf=%b want 0 11", tmo[0], flags[1:0]); else passes++;
  endtask

  task automatic test_adc_and_reset();
    do_reset();
    adte = 1'b1; tcora[7:0] = 8'h02; cclr[1:0] = 2'b01; os[3:0] = 4'b0011; tick[0] = 1'b1;
    repeat (2) step();
    checks++; if (adc_request !== 1'b0) $display("FAIL adc_early: got %b want 0", adc_request); else passes++;
    step();
    checks++; if (adc_request !== 1'b1 || tmo[0] !== 1'b1) $display("FAIL adc_pulse1: adc=%b tmo0=%b want 1 1", adc_request, tmo[0]); else passes++;
    step();
    checks++; if (adc_request !== 1'b0) $display("FAIL adc_width: got %b want 0", adc_request); else passes++;
    repeat (2) step();
    checks++; if (adc_request !== 1'b1) $display("FAIL adc_pulse2: got %b want 1", adc_request); else passes++;
    adte = 1'b0;
    repeat (3) step();
    checks++; if (adc_request !== 1'b0 || tmo[0] !== 1'b1) $display("FAIL adc_disabled: adc=%b tmo0=%b want 0 1", adc_request, tmo[0]); else passes++;
    step();
    checks++; if (tcnt[7:0] !== 8'h01 || flags[0] !== 1'b1) $display("FAIL pre_reset: tcnt0=%h cmfa=%b want 01 1", tcnt[7:0], flags[0]); else passes++;
    rst_n = 1'b0;
    #1;
    checks++; if (tcnt !== '0 || flags !== '0 || tmo !== '0)
      $display("FAIL midcount_reset: tcnt=%h flags=%b tmo=%b want 0", tcnt, flags, tmo);
    else passes++;
    step();
    rst_n = 1'b1;
    step();
    checks++; if (tcnt[7:0] !== 8'h01) $display("FAIL resume: tcnt0=%h want 01", tcnt[7:0]); else passes++;
  endtask

  initial begin
    test_reset();
    test_match_a();
    test_overflow();
    test_cascade();
    test_tmri();
    test_simul_match();
    test_adc_and_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
